// File: rtl/pc_fetch_ctrl.sv
// Purpose : fetch-PC controller at the head of IF; issues imem requests, applies stall/redirect/exception.
// Latency : redirect/exception in cycle n -> pc_o=target (req_o=1 unless stalled) and flush_o=1 in cycle n+1.
// Backpr. : stall_i holds the PC and drops req_o from the next cycle; an unacked request holds its address.
//
// Ports: clk_i/rst_i (sync, active-high) | stall_i, redir_i, redir_pc_i, exc_i, ack_i in |
//        pc_o (fetch address), req_o (request valid), flush_o (IF/ID kill pulse), fault_o (misaligned redirect pulse)
// Optional feature: PC_ALIGN_CHECK_EN turns a misaligned redirect into an exception-vector fault;
// without it the low ALIGN_BITS of the target are cleared and fault_o is constant 0.
module pc_fetch_ctrl #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC  = PC_W'(32'h0000_0000),
    parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(32'h0000_0080),
    parameter int              STEP       = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redir_i,
    input  logic [PC_W-1:0] redir_pc_i,
    input  logic            exc_i,
    input  logic            ack_i,
    output logic [PC_W-1:0] pc_o,
    output logic            req_o,
    output logic            flush_o,
    output logic            fault_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Bits of the PC that must be zero for an aligned fetch address.
    localparam logic [PC_W-1:0] LOW_MASK = ~({PC_W{1'b1}} << ALIGN_BITS);
    localparam logic [PC_W-1:0] STEP_V   = PC_W'(STEP);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] redir_tgt;
    logic            taken;
    logic            redir_bad;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic fault_q;

    assign misaligned = |(redir_pc_i & LOW_MASK);
    // A same-cycle exception outranks the alignment fault, so the fault pulse is suppressed.
    assign redir_bad  = redir_i & ~exc_i & misaligned;
    assign redir_tgt  = redir_pc_i;
    assign fault_o    = fault_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= redir_bad;
        end
    end
`else
    assign redir_bad  = 1'b0;
    assign redir_tgt  = redir_pc_i & ~LOW_MASK;
    assign fault_o    = 1'b0;
`endif

    // A misaligned redirect still counts as a taken redirect: it flushes and vectors.
    assign taken = exc_i | redir_i;
    assign req_o = (state == ST_RUN);
    assign pc_o  = pc;

    always_comb begin
        pc_nxt = pc;
        if (exc_i || redir_bad) begin
            pc_nxt = EXC_VEC;
        end else if (redir_i) begin
            pc_nxt = redir_tgt;
        end else if (!stall_i && req_o && ack_i) begin
            pc_nxt = pc + STEP_V;   // wraps modulo 2^PC_W
        end
    end

    always_comb begin
        state_nxt = state;
        if (taken) begin
            state_nxt = stall_i ? ST_HOLD : ST_RUN;
        end else begin
            case (state)
                ST_BOOT: state_nxt = ST_RUN;
                ST_RUN:  state_nxt = stall_i ? ST_HOLD : ST_RUN;
                ST_HOLD: state_nxt = stall_i ? ST_HOLD : ST_RUN;
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_BOOT;
            pc      <= RESET_VEC;
            flush_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            flush_o <= taken;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Purpose : directed bench for pc_fetch_ctrl, 32-bit and 8-bit PC instances driven in parallel.
// Latency : outputs checked 1 time unit after each rising edge (literals) and on every falling edge (model).
// Backpr. : stall/ack patterns are driven directly from the stimulus sequence.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic        exc;
    logic        ack;
    logic [31:0] redir_pc;

    logic [31:0] pc32;
    logic [7:0]  pc8;
    logic        req32, req8, fl32, fl8, ft32, ft8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    pc_fetch_ctrl u_dut32 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redir_i(redir),
        .redir_pc_i(redir_pc), .exc_i(exc), .ack_i(ack),
        .pc_o(pc32), .req_o(req32), .flush_o(fl32), .fault_o(ft32)
    );

    pc_fetch_ctrl #(
        .PC_W(8), .RESET_VEC(8'h00), .EXC_VEC(8'h80), .STEP(4), .ALIGN_BITS(2)
    ) u_dut8 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redir_i(redir),
        .redir_pc_i(redir_pc[7:0]), .exc_i(exc), .ack_i(ack),
        .pc_o(pc8), .req_o(req8), .flush_o(fl8), .fault_o(ft8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    // Reference model: index 0 = 32-bit PC, index 1 = 8-bit PC.
    logic [31:0] m_pc[2];
    bit          m_req[2];
    bit          m_flush[2];
    bit          m_fault[2];
    bit          m_boot  = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] npc;
        bit          nf;
        bit          redirect_taken;
        redirect_taken = exc || redir;
        for (int i = 0; i < 2; i++) begin
            nf = 1'b0;
            if (rst)                                            npc = 32'h0;
            else if (exc)                                       npc = 32'h80;
            else if (redir && ALIGN_CHK && redir_pc[1:0] != 2'b00) begin
                npc = 32'h80;
                nf  = 1'b1;
            end
            else if (redir)                                     npc = redir_pc & ~32'h3;
            else if (m_req[i] && ack && !stall)                 npc = m_pc[i] + 32'd4;
            else                                                npc = m_pc[i];
            m_pc[i]    <= npc & wmask(i);
            m_flush[i] <= !rst && redirect_taken;
            m_fault[i] <= !rst && nf;
            // Fetching resumes unless stalled; the first cycle after reset never fetches,
            // and the cycle after it always does unless a redirect arrives under stall.
            if (rst)                 m_req[i] <= 1'b0;
            else if (redirect_taken) m_req[i] <= !stall;
            else if (m_boot)         m_req[i] <= 1'b1;
            else                     m_req[i] <= !stall;
        end
        m_boot  <= rst;
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc32",    pc32,  m_pc[0]);
            chk("req32",   {31'b0, req32}, {31'b0, m_req[0]});
            chk("flush32", {31'b0, fl32},  {31'b0, m_flush[0]});
            chk("fault32", {31'b0, ft32},  {31'b0, m_fault[0]});
            chk("pc8",     {24'b0, pc8},   m_pc[1]);
            chk("req8",    {31'b0, req8},  {31'b0, m_req[1]});
            chk("flush8",  {31'b0, fl8},   {31'b0, m_flush[1]});
            chk("fault8",  {31'b0, ft8},   {31'b0, m_fault[1]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; exc = 1'b0; ack = 1'b1; redir_pc = 32'h0;
        step(); step();
        chk("reset_pc",    pc32, 32'h0);
        chk("reset_req",   {31'b0, req32}, 32'h0);
        chk("reset_flush", {31'b0, fl32},  32'h0);
        chk("reset_fault", {31'b0, ft32},  32'h0);

        // 1: boot cycle then sequential fetch
        rst = 1'b0;
        step();
        chk("t1_pc0",  pc32, 32'h0);
        chk("t1_req",  {31'b0, req32}, 32'h1);
        step(); chk("t1_pc4", pc32, 32'h4);
        step(); chk("t1_pc8", pc32, 32'h8);

        // 2: unacked request holds its address
        ack = 1'b0;
        step(); step(); step();
        chk("t2_pc_hold",  pc32, 32'h8);
        chk("t2_req_hold", {31'b0, req32}, 32'h1);
        ack = 1'b1;
        step(); chk("t2_pc12", pc32, 32'hC);

        // 3: stall holds PC, drops req, ack ignored
        stall = 1'b1;
        step();
        chk("t3_req0", {31'b0, req32}, 32'h0);
        chk("t3_pc12", pc32, 32'hC);
        step(); chk("t3_pc12b", pc32, 32'hC);
        stall = 1'b0;
        step();
        chk("t3_resume_req", {31'b0, req32}, 32'h1);
        chk("t3_resume_pc",  pc32, 32'hC);
        step(); chk("t3_pc16", pc32, 32'h10);

        // 4: redirect under stall with unacked request
        redir = 1'b1; redir_pc = 32'h100; stall = 1'b1; ack = 1'b0;
        step();
        chk("t4_pc",    pc32, 32'h100);
        chk("t4_flush", {31'b0, fl32},  32'h1);
        chk("t4_req",   {31'b0, req32}, 32'h0);
        redir = 1'b0;
        step(); chk("t4_flush_gone", {31'b0, fl32}, 32'h0);
        stall = 1'b0; ack = 1'b1;
        step(); chk("t4_run_pc", pc32, 32'h100);

        // 5: exception beats redirect; 8-bit wrap
        exc = 1'b1; redir = 1'b1; redir_pc = 32'h200;
        step();
        chk("t5_pc_exc", pc32, 32'h80);
        chk("t5_flush",  {31'b0, fl32}, 32'h1);
        exc = 1'b0; redir_pc = 32'hFC;
        step();
        chk("t5_pc8_fc", {24'b0, pc8}, 32'hFC);
        redir = 1'b0;
        step();
        chk("t5_pc8_wrap",  {24'b0, pc8}, 32'h0);
        chk("t5_pc32_nowrap", pc32, 32'h100);
        chk("t5_model_wrap", m_pc[1], 32'h0);

        // 6: misaligned redirect
        redir = 1'b1; redir_pc = 32'h102;
        step();
        redir = 1'b0;
        if (ALIGN_CHK) begin
            chk("t6_pc_fault", pc32, 32'h80);
            chk("t6_fault",    {31'b0, ft32}, 32'h1);
        end else begin
            chk("t6_pc_clear", pc32, 32'h100);
            chk("t6_fault",    {31'b0, ft32}, 32'h0);
        end
        chk("t6_flush", {31'b0, fl32}, 32'h1);
        step(); chk("t6_fault_pulse", {31'b0, ft32}, 32'h0);
        exc = 1'b1; redir = 1'b1; redir_pc = 32'h102;
        step();
        chk("t6_exc_pc",    pc32, 32'h80);
        chk("t6_exc_fault", {31'b0, ft32}, 32'h0);
        exc = 1'b0; redir = 1'b0;
        step();

        // Mid-operation reset, then a redirect taken straight out of BOOT
        rst = 1'b1;
        step();
        chk("t7_rst_pc",  pc32, 32'h0);
        chk("t7_rst_req", {31'b0, req32}, 32'h0);
        rst = 1'b0; redir = 1'b1; redir_pc = 32'h40;
        step();
        chk("t7_boot_redir_pc",    pc32, 32'h40);
        chk("t7_boot_redir_req",   {31'b0, req32}, 32'h1);
        chk("t7_boot_redir_flush", {31'b0, fl32},  32'h1);
        redir = 1'b0;
        step(); chk("t7_pc44", pc32, 32'h44);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
